// File: rtl/display_update_controller.sv
// display_update_controller: takes a binary count over valid/ready, converts it to two BCD
// digits by sequential double-dabble, strobes them into the display, then holds them steady.
module display_update_controller #(
  parameter int WIDTH       = 7,
  parameter int HOLD_CYCLES = 1000000,
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic             count_ready,
  output logic [3:0]       ten_count,
  output logic [3:0]       unit_count,
  output logic             load,
  output logic             digit_tick,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [7:0]       bcd_q, bcd_d, adj;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [3:0]       ten_q, ten_d, unit_q, unit_d;
  logic             overflow_q, overflow_d, load_q, load_d, tick_q, tick_d;
  logic [PW-1:0]    presc_q, presc_d;

  assign count_ready = reset_n && state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign ten_count   = ten_q;
  assign unit_count  = unit_q;
  assign overflow    = overflow_q;
  assign load        = load_q;
  assign digit_tick  = tick_q;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    ten_d      = ten_q;
    unit_d     = unit_q;
    overflow_d = overflow_q;
    load_d     = 1'b0;
    adj        = bcd_q + {bcd_q[7:4] >= 4'd5 ? 4'd3 : 4'd0, bcd_q[3:0] >= 4'd5 ? 4'd3 : 4'd0};
    case (state_q)
      IDLE: if (count_valid) begin
        state_d = CONVERT;
        bin_d   = count_in;
        bcd_d   = '0;
        cnt_d   = '0;
        ovf_d   = 32'(count_in) > 32'd99;
      end
      CONVERT: if (cnt_q == CW'(WIDTH)) begin
        state_d    = LOAD;
        load_d     = 1'b1;
        ten_d      = ovf_q || (BLANK_LZ && bcd_q[7:4] == 4'd0) ? 4'hF : bcd_q[7:4];
        unit_d     = ovf_q ? 4'hF : bcd_q[3:0];
        overflow_d = ovf_q;
      end else begin
        // the hundreds carry falls off the top; ovf already flags those values
        bcd_d = (adj << 1) | {7'd0, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
      end
      LOAD: begin
        state_d = HOLD;
        hold_d  = HW'(HOLD_CYCLES - 1);
      end
      HOLD: if (hold_q == '0) state_d = IDLE;
            else hold_d = hold_q - 1'b1;
      default: state_d = IDLE;
    endcase
    presc_d = presc_q == PW'(REFRESH_DIV - 1) ? '0 : presc_q + 1'b1;
    tick_d  = presc_d == PW'(REFRESH_DIV - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      hold_q     <= '0;
      ten_q      <= '0;
      unit_q     <= '0;
      overflow_q <= 1'b0;
      load_q     <= 1'b0;
      tick_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      ten_q      <= ten_d;
      unit_q     <= unit_d;
      overflow_q <= overflow_d;
      load_q     <= load_d;
      tick_q     <= tick_d;
      presc_q    <= presc_d;
    end
  end
endmodule

// File: tb/tb_display_update_controller.sv
// tb_display_update_controller: table-driven and random checks against a transaction-timeline
// model of the display controller.
module tb_display_update_controller;
  localparam int W = 7, H = 4, R = 8;

  logic         clk = 1'b0, reset_n = 1'b1, count_valid = 1'b0;
  logic [W-1:0] count_in = '0;
  logic         count_ready, load, digit_tick, overflow, busy;
  logic [3:0]   ten_count, unit_count;

  always #5 clk = ~clk;

  display_update_controller #(.WIDTH(W), .HOLD_CYCLES(H), .REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .count_in(count_in), .count_valid(count_valid),
    .count_ready(count_ready), .ten_count(ten_count), .unit_count(unit_count), .load(load),
    .digit_tick(digit_tick), .overflow(overflow), .busy(busy)
  );

  int vecs = 0, errs = 0, cyc_n = 0;

  bit       m_busy, m_ovf, m_load, m_tick;
  int       m_t, m_val, m_pre;
  logic [3:0] m_ten, m_unit;

  typedef struct {
    logic [W-1:0] val;
    logic [3:0]   ten;
    logic [3:0]   unit;
    logic         ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset;
    m_busy = 0; m_t = 0; m_val = 0; m_ovf = 0; m_load = 0; m_tick = 0; m_pre = 0;
    m_ten = 4'h0; m_unit = 4'h0;
  endtask

  task automatic show(input int v);
    if (v > 99) begin
      m_ten = 4'hF; m_unit = 4'hF; m_ovf = 1;
    end else begin
      m_ten  = (v / 10 == 0) ? 4'hF : 4'(v / 10);
      m_unit = 4'(v % 10);
      m_ovf  = 0;
    end
  endtask

  // accept at edge 0; digits appear after edge W+1; ready again after edge W+2+H
  task automatic model_step;
    if (!reset_n) return;
    m_load = 0;
    m_pre  = (m_pre + 1) % R;
    m_tick = (m_pre == R - 1);
    if (!m_busy) begin
      if (count_valid) begin
        m_busy = 1; m_t = 0; m_val = int'(count_in);
      end
    end else begin
      m_t++;
      if (m_t == W + 1) begin
        m_load = 1;
        show(m_val);
      end
      if (m_t == W + 2 + H) m_busy = 0;
    end
  endtask

  task automatic compare_all;
    chk("count_ready", count_ready, reset_n && !m_busy);
    chk("busy", busy, m_busy);
    chk("load", load, m_load);
    chk("digit_tick", digit_tick, m_tick);
    chk("ten_count", ten_count, m_ten);
    chk("unit_count", unit_count, m_unit);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d);
    count_valid = v;
    count_in    = d;
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_pulse(input int n);
    reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (n) cyc(1'b0, '0);
    reset_n = 1'b1;
    #1 chk("ready_after_release", count_ready, 1'b1);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 30 && m_busy; i++) cyc(1'b0, '0);
  endtask

  vec_t tbl[8];
  int   loads[$];

  initial begin
    tbl[0] = '{7'd42,  4'd4, 4'd2, 1'b0};
    tbl[1] = '{7'd7,   4'hF, 4'd7, 1'b0};
    tbl[2] = '{7'd0,   4'hF, 4'd0, 1'b0};
    tbl[3] = '{7'd99,  4'd9, 4'd9, 1'b0};
    tbl[4] = '{7'd10,  4'd1, 4'd0, 1'b0};
    tbl[5] = '{7'd100, 4'hF, 4'hF, 1'b1};
    tbl[6] = '{7'd127, 4'hF, 4'hF, 1'b1};
    tbl[7] = '{7'd5,   4'hF, 4'd5, 1'b0};

    #1 reset_pulse(3);
    repeat (18) cyc(1'b0, '0);

    foreach (tbl[i]) begin
      int  k;
      bit  seen;
      wait_idle();
      cyc(1'b1, tbl[i].val);
      k = 0; seen = 0;
      while (!seen && k < 20) begin
        cyc(1'b0, '0);
        k++;
        if (load) seen = 1;
      end
      chk("load_latency", k, W + 1);
      chk("tbl_ten", ten_count, tbl[i].ten);
      chk("tbl_unit", unit_count, tbl[i].unit);
      chk("tbl_overflow", overflow, tbl[i].ovf);
      wait_idle();
    end

    begin
      bit acc34 = 0;
      loads.delete();
      cyc(1'b1, 7'd12);
      if (load) loads.push_back(cyc_n);
      for (int i = 0; i < 40 && loads.size() < 2; i++) begin
        bit v, will_acc;
        v = !acc34;
        will_acc = !m_busy && v;
        cyc(v, 7'd34);
        if (will_acc) acc34 = 1;
        if (load) loads.push_back(cyc_n);
      end
      chk("b2b_load_count", loads.size(), 2);
      if (loads.size() == 2) chk("b2b_load_gap", loads[1] - loads[0], W + 3 + H);
      chk("b2b_second_unit", unit_count, 4'd4);
      wait_idle();
    end

    cyc(1'b1, 7'd55);
    repeat (3) cyc(1'b0, '0);
    reset_pulse(2);
    cyc(1'b1, 7'd88);
    repeat (W + 1) cyc(1'b0, '0);
    chk("post_reset_load", load, 1'b1);
    chk("post_reset_ten", ten_count, 4'd8);
    wait_idle();

    cyc(1'b1, 7'd23);
    repeat (10) cyc(1'b0, '0);
    reset_pulse(2);

    for (int i = 0; i < 500; i++) cyc(($urandom % 3) == 0, W'($urandom % 128));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
